// File: rtl/h_lock_pkg.sv
// rtl/h_lock_pkg.sv - shared types and widths for the lock password path
package h_lock_pkg;

  localparam int CODE_W = 16;
  localparam int FAIL_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ENTRY    = 3'd1,
    ST_COMPARE  = 3'd2,
    ST_UNLOCKED = 3'd3,
    ST_LOCKOUT  = 3'd4
  } lock_state_t;

endpackage

// File: rtl/h_btn_edge.sv
// rtl/h_btn_edge.sv - button synchronizer with one-cycle release pulse
module h_btn_edge (
  input  logic clk_in,
  input  logic rst_n,
  input  logic btn_in,
  output logic pulse_out
);

  logic sync_q1;
  logic sync_q2;
  logic sync_q3;

  // sync_q3 lags sync_q2 by one cycle; a 1->0 step there is a release
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      sync_q1   <= 1'b0;
      sync_q2   <= 1'b0;
      sync_q3   <= 1'b0;
      pulse_out <= 1'b0;
    end else begin
      sync_q1   <= btn_in;
      sync_q2   <= sync_q1;
      sync_q3   <= sync_q2;
      pulse_out <= sync_q3 & ~sync_q2;
    end
  end

endmodule

// File: rtl/h_unlock_check.sv
// rtl/h_unlock_check.sv - password check FSM with failure counting and timed lockout
module h_unlock_check
  import h_lock_pkg::*;
#(
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned UNLOCK_CYCLES  = 32'd500_000_000,
  parameter int unsigned LOCKOUT_CYCLES = 32'd3_000_000_000,
  parameter int unsigned TIMER_W        = 32
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              enb_check,
  input  logic [CODE_W-1:0] value_16bit,
  input  logic [CODE_W-1:0] password,
  input  logic              confirm_button,
  input  logic              exit_button,
  output logic              unlocked,
  output logic              alarm,
  output logic              wrong_pulse,
  output logic [FAIL_W-1:0] fail_count,
  output logic [2:0]        state_dbg
);

  localparam logic [TIMER_W-1:0] UNLOCK_LOAD  = TIMER_W'(UNLOCK_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCKOUT_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);
  localparam logic [FAIL_W-1:0]  FAIL_SAT     = FAIL_W'(MAX_TRIES);

  lock_state_t        state;
  logic [CODE_W-1:0]  code_q;
  logic [TIMER_W-1:0] timer;
  logic               confirm_pulse;
  logic               exit_pulse;
  logic               last_try;

  h_btn_edge u_confirm (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .btn_in    (confirm_button),
    .pulse_out (confirm_pulse)
  );

  h_btn_edge u_exit (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .btn_in    (exit_button),
    .pulse_out (exit_pulse)
  );

  assign last_try  = (32'(fail_count) + 32'd1) >= MAX_TRIES;
  assign state_dbg = state;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      code_q      <= '0;
      timer       <= '0;
      unlocked    <= 1'b0;
      alarm       <= 1'b0;
      wrong_pulse <= 1'b0;
      fail_count  <= '0;
    end else begin
      wrong_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enb_check) state <= ST_ENTRY;
        end
        ST_ENTRY: begin
          // exit outranks confirm so a simultaneous release captures nothing
          if (!enb_check || exit_pulse) begin
            state <= ST_IDLE;
          end else if (confirm_pulse) begin
            code_q <= value_16bit;
            state  <= ST_COMPARE;
          end
        end
        ST_COMPARE: begin
          if (code_q == password) begin
            fail_count <= '0;
            timer      <= UNLOCK_LOAD;
            unlocked   <= 1'b1;
            state      <= ST_UNLOCKED;
          end else begin
            wrong_pulse <= 1'b1;
            if (last_try) begin
              fail_count <= FAIL_SAT;
              timer      <= LOCKOUT_LOAD;
              alarm      <= 1'b1;
              state      <= ST_LOCKOUT;
            end else begin
              fail_count <= fail_count + 1'b1;
              state      <= ST_ENTRY;
            end
          end
        end
        ST_UNLOCKED: begin
          if (timer == '0 || exit_pulse) begin
            unlocked <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_LOCKOUT: begin
          if (timer == '0) begin
            alarm      <= 1'b0;
            fail_count <= '0;
            state      <= ST_IDLE;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_h_unlock_check.sv
// tb/tb_h_unlock_check.sv - self-checking bench for h_unlock_check
module tb_h_unlock_check;

  localparam int MT = 3;
  localparam int UC = 20;
  localparam int LC = 50;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        enb_check;
  logic [15:0] value_16bit;
  logic [15:0] password;
  logic        confirm_button;
  logic        exit_button;
  logic        unlocked;
  logic        alarm;
  logic        wrong_pulse;
  logic [3:0]  fail_count;
  logic [2:0]  state_dbg;

  int passed = 0;
  int total  = 0;
  bit cmp_en = 0;
  int wcnt = 0;
  int ucnt = 0;
  int acnt = 0;

  h_unlock_check #(
    .MAX_TRIES(MT), .UNLOCK_CYCLES(UC), .LOCKOUT_CYCLES(LC), .TIMER_W(32)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .enb_check(enb_check),
    .value_16bit(value_16bit), .password(password),
    .confirm_button(confirm_button), .exit_button(exit_button),
    .unlocked(unlocked), .alarm(alarm), .wrong_pulse(wrong_pulse),
    .fail_count(fail_count), .state_dbg(state_dbg)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // reference model: pin history gives release events, deadlines give dwell times
  int   m_state = 0, m_fail = 0, m_unl = 0, m_alarm = 0, m_wrong = 0;
  int   m_code = 0, m_end = 0, cyc = 0;
  logic hc[4] = '{default: 1'b0};
  logic he[4] = '{default: 1'b0};

  always @(posedge clk_in) begin
    bit cp, ep;
    if (!rst_n) begin
      m_state = 0; m_fail = 0; m_unl = 0; m_alarm = 0; m_wrong = 0; m_code = 0;
      hc = '{default: 1'b0};
      he = '{default: 1'b0};
    end else begin
      cp = hc[0] && !hc[1];
      ep = he[0] && !he[1];
      for (int i = 0; i < 3; i++) begin
        hc[i] = hc[i+1];
        he[i] = he[i+1];
      end
      hc[3] = confirm_button;
      he[3] = exit_button;
      m_wrong = 0;
      case (m_state)
        0: if (enb_check) m_state = 1;
        1: if (!enb_check || ep) m_state = 0;
           else if (cp) begin m_code = int'(value_16bit); m_state = 2; end
        2: if (m_code == int'(password)) begin
             m_fail = 0; m_unl = 1; m_end = cyc + UC; m_state = 3;
           end else if (m_fail + 1 < MT) begin
             m_wrong = 1; m_fail++; m_state = 1;
           end else begin
             m_wrong = 1; m_fail = MT; m_alarm = 1; m_end = cyc + LC; m_state = 4;
           end
        3: if (cyc == m_end || ep) begin m_unl = 0; m_state = 0; end
        4: if (cyc == m_end) begin m_alarm = 0; m_fail = 0; m_state = 0; end
        default: m_state = 0;
      endcase
    end
    cyc++;
  end

  always @(negedge clk_in) begin
    if (cmp_en) begin
      chk("unlocked", int'(unlocked), m_unl);
      chk("alarm", int'(alarm), m_alarm);
      chk("wrong_pulse", int'(wrong_pulse), m_wrong);
      chk("fail_count", int'(fail_count), m_fail);
      chk("state_dbg", int'(state_dbg), m_state);
      chk("exclusive", int'(unlocked & alarm), 0);
      wcnt += int'(wrong_pulse);
      ucnt += int'(unlocked);
      acnt += int'(alarm);
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      #2;
    end
  endtask

  task automatic press_confirm(input int hold);
    confirm_button = 1'b1;
    tick(hold);
    confirm_button = 1'b0;
  endtask

  task automatic press_exit(input int hold);
    exit_button = 1'b1;
    tick(hold);
    exit_button = 1'b0;
  endtask

  task automatic wait_unlocked_low(input string nm);
    for (int i = 0; i < 60 && unlocked; i++) tick(1);
    chk(nm, int'(unlocked), 0);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; enb_check = 1'b0; value_16bit = '0; password = 16'hBEEF;
    confirm_button = 1'b0; exit_button = 1'b0;
    tick(3);
    chk("rst_state", int'(state_dbg), 0);
    chk("rst_unlocked", int'(unlocked), 0);
    chk("rst_fail", int'(fail_count), 0);
    cmp_en = 1;
    rst_n = 1'b1;

    // correct code: latency and dwell
    enb_check = 1'b1; value_16bit = 16'hBEEF;
    tick(2);
    press_confirm(3);
    lat = 0;
    for (int i = 0; i < 10 && !unlocked; i++) begin tick(1); lat++; end
    chk("unlock_latency", lat, 5);
    ucnt = 0;
    wait_unlocked_low("unlock_end_timeout");
    chk("unlock_cycles", ucnt, UC);
    chk("idle_after_unlock", int'(state_dbg), 0);

    // two wrong codes, then correct
    wcnt = 0;
    value_16bit = 16'h1234;
    tick(2);
    press_confirm(2); tick(8);
    chk("fail_after_1", int'(fail_count), 1);
    press_confirm(2); tick(8);
    chk("fail_after_2", int'(fail_count), 2);
    chk("wrong_strobes", wcnt, 2);
    value_16bit = 16'hBEEF;
    press_confirm(2); tick(6);
    chk("unlock_after_retry", int'(unlocked), 1);
    chk("fail_cleared", int'(fail_count), 0);
    wait_unlocked_low("retry_unlock_end");

    // three wrong codes: lockout ignores buttons
    value_16bit = 16'h1234;
    tick(2);
    press_confirm(2); tick(8);
    press_confirm(2); tick(8);
    acnt = 0;
    press_confirm(2); tick(8);
    press_exit(3); press_confirm(3); tick(5);
    chk("lockout_state", int'(state_dbg), 4);
    chk("lockout_fail", int'(fail_count), MT);
    for (int i = 0; i < 100 && alarm; i++) tick(1);
    chk("alarm_cycles", acnt, LC);
    chk("post_lock_fail", int'(fail_count), 0);
    chk("post_lock_state", int'(state_dbg), 0);

    // simultaneous confirm/exit release in ENTRY
    tick(3);
    press_confirm(2); tick(8);
    wcnt = 0;
    confirm_button = 1'b1; exit_button = 1'b1;
    tick(2);
    confirm_button = 1'b0; exit_button = 1'b0;
    lat = 0;
    for (int i = 0; i < 10 && state_dbg != 3'd0; i++) begin tick(1); lat++; end
    chk("both_to_idle", int'(state_dbg), 0);
    tick(4);
    chk("both_no_wrong", wcnt, 0);
    chk("both_fail_kept", int'(fail_count), 1);

    // exit during UNLOCKED
    value_16bit = 16'hBEEF;
    press_confirm(2);
    for (int i = 0; i < 10 && !unlocked; i++) tick(1);
    chk("exit_test_unlocked", int'(unlocked), 1);
    exit_button = 1'b1;
    tick(4);
    exit_button = 1'b0;
    lat = 0;
    for (int i = 0; i < 10 && unlocked; i++) begin tick(1); lat++; end
    chk("exit_drop_latency", lat, 4);

    // long confirm hold gives one compare
    value_16bit = 16'h1234;
    tick(2);
    wcnt = 0;
    press_confirm(10); tick(8);
    chk("long_hold_strobes", wcnt, 1);
    chk("long_hold_fail", int'(fail_count), 1);

    // reset mid-lockout
    press_confirm(2); tick(8);
    press_confirm(2); tick(10);
    chk("mid_lock_alarm", int'(alarm), 1);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("rst_lock_alarm", int'(alarm), 0);
    chk("rst_lock_fail", int'(fail_count), 0);
    chk("rst_lock_state", int'(state_dbg), 0);
    enb_check = 1'b0;
    tick(3);
    cmp_en = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
